// File: rtl/adder_tree_pipe_acc.sv
// Pipelined adder tree summing one line per cycle, plus an accumulator that totals
// ACC_LINES line sums per window. Optional saturating accumulator: define ADDER_TREE_SAT_EN.
module adder_tree_pipe_acc #(
   parameter int LINE_SIZE = 16,
   parameter int DATA_W    = 16,
   parameter int ACC_LINES = 4,
   parameter int ACC_W     = DATA_W + $clog2(LINE_SIZE) + $clog2(ACC_LINES)
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 valid_in,
   input  logic [DATA_W-1:0]                    line_in [LINE_SIZE-1:0],
   input  logic                                 clear_acc,
   output logic [DATA_W+$clog2(LINE_SIZE)-1:0]  line_sum_out,
   output logic                                 line_sum_valid,
   output logic [ACC_W-1:0]                     acc_out,
   output logic                                 acc_valid,
   output logic [$clog2(ACC_LINES+1)-1:0]       acc_count,
   output logic                                 acc_sat
);

   localparam int L      = $clog2(LINE_SIZE);
   localparam int SUM_W  = DATA_W + L;
   localparam int LEAVES = 2 ** L;
   localparam int NODES  = LEAVES - 1;
   localparam int CNT_W  = $clog2(ACC_LINES + 1);

`ifdef ADDER_TREE_SAT_EN
   localparam int EXT_W = ACC_W + 1;
`else
   localparam int EXT_W = ACC_W;
`endif

   // Handshake: valid_in qualifies line_in for one cycle; there is no ready, the
   // tree accepts a line every cycle and line_sum_valid marks the matching result.

   // Tree stored heap-style: node n has children 2n+1 and 2n+2, indices past the
   // last internal node refer to leaves. All nodes of one depth form one stage.
   logic [SUM_W-1:0] leaf   [LEAVES];
   logic [SUM_W-1:0] node   [NODES];
   logic [SUM_W-1:0] kid_a  [NODES];
   logic [SUM_W-1:0] kid_b  [NODES];
   logic [L-1:0]     valid_pipe;

   for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
      if (g < LINE_SIZE) begin : g_real
         assign leaf[g] = SUM_W'(line_in[g]);
      end else begin : g_pad
         assign leaf[g] = '0;
      end
   end

   for (genvar n = 0; n < NODES; n++) begin : g_node
      if (2 * n + 1 >= NODES) begin : g_from_leaf
         assign kid_a[n] = leaf[2*n+1-NODES];
         assign kid_b[n] = leaf[2*n+2-NODES];
      end else begin : g_from_node
         assign kid_a[n] = node[2*n+1];
         assign kid_b[n] = node[2*n+2];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int n = 0; n < NODES; n++) node[n] <= '0;
         valid_pipe <= '0;
      end else begin
         for (int n = 0; n < NODES; n++) node[n] <= kid_a[n] + kid_b[n];
         valid_pipe <= (valid_pipe << 1) | L'(valid_in);
      end
   end

   assign line_sum_out   = node[0];
   assign line_sum_valid = valid_pipe[L-1];

   // Accumulator: CLOSE means the next line sum completes the window.
   typedef enum logic {ACC_OPEN, ACC_CLOSE} acc_state_t;

   acc_state_t       acc_state;
   logic [ACC_W-1:0] acc_reg;
   logic [ACC_W-1:0] acc_base;
   logic [EXT_W-1:0] acc_sum;
   logic [ACC_W-1:0] acc_next;
   logic             acc_clamp;
   logic [CNT_W-1:0] cnt_base;
   logic             close_now;

   always_comb begin
      cnt_base  = clear_acc ? '0 : acc_count;
      close_now = clear_acc ? (ACC_LINES == 1) : (acc_state == ACC_CLOSE);
      acc_base  = (cnt_base == '0) ? '0 : acc_reg;
      acc_sum   = EXT_W'(acc_base) + EXT_W'(line_sum_out);
`ifdef ADDER_TREE_SAT_EN
      acc_clamp = acc_sum[ACC_W];
      acc_next  = acc_clamp ? '1 : acc_sum[ACC_W-1:0];
`else
      acc_clamp = 1'b0;
      acc_next  = acc_sum;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_state <= (ACC_LINES == 1) ? ACC_CLOSE : ACC_OPEN;
         acc_reg   <= '0;
         acc_out   <= '0;
         acc_valid <= 1'b0;
         acc_count <= '0;
         acc_sat   <= 1'b0;
      end else begin
         acc_valid <= 1'b0;
         if (line_sum_valid) begin
            acc_sat <= acc_sat | acc_clamp;
            acc_reg <= acc_next;
            if (close_now) begin
               acc_out   <= acc_next;
               acc_valid <= 1'b1;
               acc_count <= '0;
               acc_state <= (ACC_LINES == 1) ? ACC_CLOSE : ACC_OPEN;
            end else begin
               acc_count <= cnt_base + CNT_W'(1);
               acc_state <= (cnt_base == CNT_W'(ACC_LINES - 2)) ? ACC_CLOSE : ACC_OPEN;
            end
         end else if (clear_acc) begin
            acc_count <= '0;
            acc_state <= (ACC_LINES == 1) ? ACC_CLOSE : ACC_OPEN;
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_pipe_acc.sv
// Directed bench for adder_tree_pipe_acc: default build, a 5-element build and a
// 20-bit accumulator build share clock, reset, valid and clear.
module tb_adder_tree_pipe_acc;

   localparam int LS = 16;
   localparam int DW = 16;
   localparam int SW = 20;
   localparam int AW = 22;

`ifdef ADDER_TREE_SAT_EN
   localparam logic [63:0] EXP_W_OVF = 64'd1048575;
   localparam logic [63:0] EXP_W_SAT = 64'd1;
`else
   localparam logic [63:0] EXP_W_OVF = 64'd1048512;
   localparam logic [63:0] EXP_W_SAT = 64'd0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          valid_in = 1'b0;
   logic          clear_acc = 1'b0;
   logic [DW-1:0] line_in [LS-1:0];
   logic [DW-1:0] line5   [4:0];

   logic [SW-1:0] line_sum_out;
   logic          line_sum_valid;
   logic [AW-1:0] acc_out;
   logic          acc_valid;
   logic [2:0]    acc_count;
   logic          acc_sat;

   logic [18:0]   line_sum_out5;
   logic          line_sum_valid5;
   logic [20:0]   acc_out5;
   logic          acc_valid5;
   logic [2:0]    acc_count5;
   logic          acc_sat5;

   logic [SW-1:0] line_sum_out_w;
   logic          line_sum_valid_w;
   logic [19:0]   acc_out_w;
   logic          acc_valid_w;
   logic [2:0]    acc_count_w;
   logic          acc_sat_w;

   logic [AW-1:0] lsum_q[$];
   logic [AW-1:0] acc_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   adder_tree_pipe_acc dut (
      .CLK(CLK), .RST(RST), .valid_in(valid_in), .line_in(line_in), .clear_acc(clear_acc),
      .line_sum_out(line_sum_out), .line_sum_valid(line_sum_valid), .acc_out(acc_out),
      .acc_valid(acc_valid), .acc_count(acc_count), .acc_sat(acc_sat)
   );

   adder_tree_pipe_acc #(.LINE_SIZE(5)) dut5 (
      .CLK(CLK), .RST(RST), .valid_in(valid_in), .line_in(line5), .clear_acc(clear_acc),
      .line_sum_out(line_sum_out5), .line_sum_valid(line_sum_valid5), .acc_out(acc_out5),
      .acc_valid(acc_valid5), .acc_count(acc_count5), .acc_sat(acc_sat5)
   );

   adder_tree_pipe_acc #(.ACC_W(20)) dutw (
      .CLK(CLK), .RST(RST), .valid_in(valid_in), .line_in(line_in), .clear_acc(clear_acc),
      .line_sum_out(line_sum_out_w), .line_sum_valid(line_sum_valid_w), .acc_out(acc_out_w),
      .acc_valid(acc_valid_w), .acc_count(acc_count_w), .acc_sat(acc_sat_w)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic set_line(input logic [DW-1:0] v);
      for (int i = 0; i < LS; i++) line_in[i] = v;
   endtask

   task automatic send_line(input logic [DW-1:0] v);
      set_line(v);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_acc = 1'b1;
      tick();
      clear_acc = 1'b0;
   endtask

   task automatic push_lines(input logic [AW-1:0] s, input int n);
      repeat (n) lsum_q.push_back(s);
   endtask

   // Scoreboard: every line sum and window total must match the expected queues
   always @(negedge CLK) begin
      if (line_sum_valid === 1'b1) begin
         if (lsum_q.size() == 0) check("lsum_unexpected", line_sum_valid, 0);
         else check("lsum", line_sum_out, lsum_q.pop_front());
      end
      if (acc_valid === 1'b1) begin
         if (acc_q.size() == 0) check("acc_unexpected", acc_valid, 0);
         else check("acc", acc_out, acc_q.pop_front());
      end
      if (line_sum_valid5 === 1'b1) check("lsum5", line_sum_out5, 15);
   end

   initial begin
      set_line('0);
      for (int i = 0; i < 5; i++) line5[i] = DW'(i + 1);
      idle(3);
      RST = 1'b0;

      // reset state
      check("rst_lsv", line_sum_valid, 0);
      check("rst_lsum", line_sum_out, 0);
      check("rst_acc_valid", acc_valid, 0);
      check("rst_acc_out", acc_out, 0);
      check("rst_acc_count", acc_count, 0);
      check("rst_acc_sat", acc_sat, 0);

      // single full-scale line: latency 4 (default) and 3 (5-element build)
      lsum_q.push_back(1048560);
      set_line(16'hFFFF);
      valid_in = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         valid_in = 1'b0;
         check($sformatf("t1_lsv_e%0d", e), line_sum_valid, e == 4);
         check($sformatf("t1_lsv5_e%0d", e), line_sum_valid5, e == 3);
      end
      check("t1_count", acc_count, 1);
      pulse_clear();
      check("t1_clear_count", acc_count, 0);
      check("t1_clear_acc_out", acc_out, 0);

      // back-to-back window
      lsum_q.push_back(16); lsum_q.push_back(32); lsum_q.push_back(48); lsum_q.push_back(64);
      acc_q.push_back(160);
      for (int j = 0; j < 4; j++) begin
         set_line(DW'(j + 1));
         valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      check("t2_lsv_0", line_sum_valid, 1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("t2_lsv_%0d", k), line_sum_valid, 1);
      end
      check("t2_count3", acc_count, 3);
      tick();
      check("t2_acc_valid", acc_valid, 1);
      check("t2_acc_out", acc_out, 160);
      check("t2_count0", acc_count, 0);
      check("t2_lsv_end", line_sum_valid, 0);
      tick();
      check("t2_acc_valid_off", acc_valid, 0);

      // same window with bubbles
      lsum_q.push_back(16); lsum_q.push_back(32); lsum_q.push_back(48); lsum_q.push_back(64);
      acc_q.push_back(160);
      for (int j = 0; j < 4; j++) begin
         send_line(DW'(j + 1));
         idle(2);
      end
      idle(4);
      check("t3_acc_q", acc_q.size(), 0);
      check("t3_count", acc_count, 0);

      // partial window dropped by clear, then a full window
      push_lines(16, 2);
      send_line(1); send_line(1);
      idle(5);
      check("t4_count2", acc_count, 2);
      pulse_clear();
      check("t4_clear_count", acc_count, 0);
      check("t4_acc_held", acc_out, 160);
      push_lines(32, 4);
      acc_q.push_back(128);
      repeat (4) send_line(2);
      idle(5);
      check("t4_acc_out", acc_out, 128);
      check("t4_count0", acc_count, 0);

      // clear coinciding with a line sum starts a new window at 1
      push_lines(16, 3);
      send_line(1); send_line(1);
      idle(5);
      check("t4b_count2", acc_count, 2);
      send_line(1);
      idle(3);
      check("t4b_lsv", line_sum_valid, 1);
      pulse_clear();
      check("t4b_count1", acc_count, 1);
      pulse_clear();
      check("t4b_count0", acc_count, 0);

      // overflow on the 20-bit accumulator
      push_lines(1048560, 4);
      acc_q.push_back(4194240);
      repeat (4) send_line(16'hFFFF);
      idle(5);
      check("t5_acc_out", acc_out, 4194240);
      check("t5_sat", acc_sat, 0);
      check("t5_w_acc_out", acc_out_w, EXP_W_OVF);
      check("t5_w_sat", acc_sat_w, EXP_W_SAT);
      push_lines(16, 4);
      acc_q.push_back(64);
      repeat (4) send_line(1);
      idle(5);
      check("t5_w_acc_next", acc_out_w, 64);
      check("t5_w_sat_held", acc_sat_w, EXP_W_SAT);

      // reset with lines in flight
      lsum_q.push_back(48);
      repeat (3) send_line(3);
      tick();
      check("t6_lsv_before", line_sum_valid, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t6_acc_out", acc_out, 0);
      check("t6_count", acc_count, 0);
      check("t6_w_sat", acc_sat_w, 0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t6_lsv_%0d", k), line_sum_valid, 0);
         check($sformatf("t6_acc_valid_%0d", k), acc_valid, 0);
         tick();
      end
      push_lines(16, 4);
      acc_q.push_back(64);
      repeat (4) send_line(1);
      idle(5);
      check("t6_acc_out_after", acc_out, 64);
      check("t6_count_after", acc_count, 0);

      // report
      check("lsum_q_left", lsum_q.size(), 0);
      check("acc_q_left", acc_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
